// File: rtl/keymap_pkg.sv
// keymap_pkg: shared types and constants for the keymap RAM access controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package keymap_pkg;

  localparam int KM_AW  = 11;
  localparam int CPU_AW = 12;

  // Bit offsets of the fields inside one 16-bit keymap word
  localparam int KM_ROW1_LSB = 13;
  localparam int KM_COL1_LSB = 8;
  localparam int KM_ROW2_LSB = 5;
  localparam int KM_COL2_LSB = 0;

  // Byte enables: keymap1 lives in the high byte, keymap2 in the low byte
  localparam logic [1:0] KM1_BE = 2'b10;
  localparam logic [1:0] KM2_BE = 2'b01;

  typedef struct packed {
    logic [2:0] row1;
    logic [4:0] col1;
    logic [2:0] row2;
    logic [4:0] col2;
  } km_word_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEYRD    = 3'd1,
    ST_KEYRET   = 3'd2,
    ST_CPURD    = 3'd3,
    ST_CPURDDAT = 3'd4,
    ST_CPUWR    = 3'd5,
    ST_CPUWAIT  = 3'd6
  } km_state_e;

endpackage

// File: rtl/keymap_cpu_ptr.sv
// keymap_cpu_ptr: CPU byte pointer with rewind and increment, split into word address and byte lane.
// Latency: rewind/increment take effect on the next clk edge.
// Backpressure: none; the controller issues at most one increment per CPU access.
module keymap_cpu_ptr #(
  parameter int CPU_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rewind,
  input  logic              inc,
  output logic [CPU_AW-1:0] ptr,
  output logic [CPU_AW-2:0] word_addr,
  output logic              lane
);

  // Pointer register; rewind wins over increment, wraps naturally at the top
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (rewind) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

  assign word_addr = ptr[CPU_AW-1:1];
  assign lane      = ptr[0];

endmodule

// File: rtl/keymap_access_ctrl.sv
// keymap_access_ctrl: shares the single-port keymap RAM between scancode lookups and the CPU byte port.
// Latency: key_req to key_ack 3 cycles when idle, at most 3 more behind an in-flight CPU access.
// Backpressure: none; a pending lookup is overwritten latest-wins, CPU strobes are held until release.
// Optional feature macro KEYMAP_READBACK_EN: enables CPU readback; without it dout stays 8'hFF.
module keymap_access_ctrl
  import keymap_pkg::*;
#(
  parameter int KM_AW  = keymap_pkg::KM_AW,
  parameter int CPU_AW = keymap_pkg::CPU_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_req,
  input  logic [KM_AW-1:0] key_addr,
  output logic             key_ack,
  output logic [15:0]      key_data,
  input  logic             cpuread,
  input  logic             cpuwrite,
  input  logic             rewind,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic [KM_AW-1:0] ram_addr,
  output logic [1:0]       ram_we,
  output logic [15:0]      ram_wdata,
  input  logic [15:0]      ram_rdata
);

  km_state_e        state_q, state_nxt;
  logic             key_pend_q;
  logic [KM_AW-1:0] key_addr_q;
  logic             key_ret_q, key_ret_nxt;
  logic [KM_AW-1:0] ram_addr_nxt;
  logic [1:0]       ram_we_nxt;
  logic             key_ack_nxt;
  logic [15:0]      key_data_nxt;
  logic [7:0]       dout_nxt;
  logic             pend_clr;
  logic             ptr_inc;
  logic             ptr_rewind;
  logic [CPU_AW-1:0] cpuptr;
  logic [CPU_AW-2:0] word_addr;
  logic              lane;

  keymap_cpu_ptr #(.CPU_AW(CPU_AW)) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .rewind    (ptr_rewind),
    .inc       (ptr_inc),
    .ptr       (cpuptr),
    .word_addr (word_addr),
    .lane      (lane)
  );

  assign ram_wdata = {din, din};

  // Lookup capture: a new strobe always re-arms pending and replaces the address
  always_ff @(posedge clk) begin
    if (rst) begin
      key_pend_q <= 1'b0;
      key_addr_q <= '0;
    end else if (key_req) begin
      key_pend_q <= 1'b1;
      key_addr_q <= key_addr;
    end else if (pend_clr) begin
      key_pend_q <= 1'b0;
    end
  end

  // Next-state and registered-output decode; lookups take priority over CPU work
  always_comb begin
    state_nxt    = state_q;
    ram_addr_nxt = ram_addr;
    ram_we_nxt   = 2'b00;
    key_ack_nxt  = 1'b0;
    key_data_nxt = key_data;
    dout_nxt     = dout;
    key_ret_nxt  = key_ret_q;
    pend_clr     = 1'b0;
    ptr_inc      = 1'b0;
    ptr_rewind   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_pend_q) begin
          ram_addr_nxt = key_addr_q;
          pend_clr     = 1'b1;
          key_ret_nxt  = 1'b0;
          state_nxt    = ST_KEYRD;
        end else if (rewind) begin
          ptr_rewind = 1'b1;
        end else if (key_req) begin
          // A strobe arriving this cycle becomes pending next cycle; hold off
          // CPU work so the lookup is served first.
          state_nxt = ST_IDLE;
        end else if (cpuread) begin
`ifdef KEYMAP_READBACK_EN
          ram_addr_nxt = word_addr;
          state_nxt    = ST_CPURD;
`else
          state_nxt    = ST_CPUWAIT;
`endif
        end else if (cpuwrite) begin
          ram_addr_nxt = word_addr;
          ram_we_nxt   = lane ? KM2_BE : KM1_BE;
          state_nxt    = ST_CPUWR;
        end
      end
      ST_KEYRD: state_nxt = ST_KEYRET;
      ST_KEYRET: begin
        key_data_nxt = ram_rdata;
        key_ack_nxt  = 1'b1;
        key_ret_nxt  = 1'b0;
        state_nxt    = key_ret_q ? ST_CPUWAIT : ST_IDLE;
      end
`ifdef KEYMAP_READBACK_EN
      ST_CPURD: state_nxt = ST_CPURDDAT;
      ST_CPURDDAT: begin
        dout_nxt  = lane ? ram_rdata[7:0] : ram_rdata[15:8];
        state_nxt = ST_CPUWAIT;
      end
`endif
      ST_CPUWR: state_nxt = ST_CPUWAIT;
      ST_CPUWAIT: begin
        if (key_pend_q) begin
          ram_addr_nxt = key_addr_q;
          pend_clr     = 1'b1;
          key_ret_nxt  = 1'b1;
          state_nxt    = ST_KEYRD;
        end else if (!cpuread && !cpuwrite) begin
          ptr_inc   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ram_addr  <= '0;
      ram_we    <= 2'b00;
      key_ack   <= 1'b0;
      key_data  <= 16'h0000;
      dout      <= 8'hFF;
      key_ret_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_we    <= ram_we_nxt;
      key_ack   <= key_ack_nxt;
      key_data  <= key_data_nxt;
      dout      <= dout_nxt;
      key_ret_q <= key_ret_nxt;
    end
  end

endmodule

// File: tb/tb_keymap_access_ctrl.sv
// tb_keymap_access_ctrl: randomized bench for keymap_access_ctrl against a RAM-image and pointer model.
// Latency: checks lookup latency of 3 when idle, bounded otherwise.
// Backpressure: CPU strobes held long enough for the access to reach its wait state.
module tb_keymap_access_ctrl;
  import keymap_pkg::*;

  logic        clk, rst;
  logic        key_req, key_ack, cpuread, cpuwrite, rewind;
  logic [10:0] key_addr, ram_addr;
  logic [15:0] key_data, ram_wdata, ram_rdata;
  logic [7:0]  din, dout;
  logic [1:0]  ram_we;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int we_cycles = 0;

  logic [15:0] mem     [0:2047];
  logic [15:0] ref_mem [0:2047];
  logic [11:0] ref_ptr;
  logic        pl_en;
  logic [10:0] pl_addr;
  logic [15:0] pl_data;

  typedef struct {
    logic [15:0] d;
    int          n;
    bit          strict;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  keymap_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_req   (key_req),
    .key_addr  (key_addr),
    .key_ack   (key_ack),
    .key_data  (key_data),
    .cpuread   (cpuread),
    .cpuwrite  (cpuwrite),
    .rewind    (rewind),
    .din       (din),
    .dout      (dout),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM, 1-cycle read latency, byte writes; bench preload port
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else begin
      if (ram_we[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
      if (ram_we[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
    end
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected byte for a CPU read at byte pointer p
  function automatic logic [7:0] exp_rd_byte(input logic [11:0] p);
`ifdef KEYMAP_READBACK_EN
    return p[0] ? ref_mem[p[11:1]][7:0] : ref_mem[p[11:1]][15:8];
`else
    return 8'hFF;
`endif
  endfunction

  task automatic ref_wr(input logic [7:0] b);
    if (ref_ptr[0]) ref_mem[ref_ptr[11:1]][7:0] = b;
    else            ref_mem[ref_ptr[11:1]][15:8] = b;
    ref_ptr = ref_ptr + 12'd1;
  endtask

  task automatic key_lookup(input logic [10:0] a, input bit strict);
    exp_t e;
    e.d = ref_mem[a];
    e.n = cyc + 1;
    e.strict = strict;
    exp_q.push_back(e);
    key_addr = a;
    key_req  = 1'b1;
    tick();
    key_req  = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] b, input int hold);
    din = b;
    cpuwrite = 1'b1;
    repeat (hold) tick();
    cpuwrite = 1'b0;
    repeat (4) tick();
    ref_wr(b);
  endtask

  task automatic cpu_read(input int hold, input int gap, input bit do_chk, input string tag);
    logic [7:0] e;
    e = exp_rd_byte(ref_ptr);
    cpuread = 1'b1;
    repeat (hold) tick();
    cpuread = 1'b0;
    repeat (gap) tick();
    if (do_chk) chk(tag, dout, e);
    ref_ptr = ref_ptr + 12'd1;
  endtask

  task automatic rewind_ptr();
    rewind = 1'b1;
    repeat (2) tick();
    rewind = 1'b0;
    tick();
    ref_ptr = '0;
  endtask

  // Lookup scoreboard: every ack must match an outstanding request in order
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we != 2'b00) we_cycles++;
      if (key_ack) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          chk("spurious_ack", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("key_data", key_data, mon_e.d);
          if (mon_e.strict) chk("key_lat", cyc - mon_e.n, 3);
          else              chk("key_lat_max", ((cyc - mon_e.n) <= 6) ? 1 : 0, 1);
        end
      end
    end
  end

  initial begin
    int we0, a0, op, seen;
    logic [7:0]  b, e_rd;
    logic [10:0] ka;

    rst = 1'b1; key_req = 1'b0; key_addr = '0; cpuread = 1'b0; cpuwrite = 1'b0;
    rewind = 1'b0; din = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0; ref_ptr = '0;

    for (int i = 0; i < 2048; i++) begin
      pl_en   = 1'b1;
      pl_addr = i[10:0];
      pl_data = (i == 28) ? 16'h2144 : 16'($urandom);
      ref_mem[i] = pl_data;
      tick();
    end
    pl_en = 1'b0;
    tick();

    chk("rst_key_ack",  key_ack,  0);
    chk("rst_key_data", key_data, 16'h0000);
    chk("rst_dout",     dout,     8'hFF);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we",   ram_we,   2'b00);
    chk("rst_cpuptr",   dut.cpuptr, 0);
    rst = 1'b0;
    tick();

    // Single lookup from idle
    key_lookup(11'h01C, 1'b1);
    repeat (5) tick();
    chk("t1_key_data", key_data, 16'h2144);

    // Two CPU byte writes after rewind
    rewind_ptr();
    we0 = we_cycles;
    cpu_write(8'hA5, 4);
    cpu_write(8'h3C, 4);
    chk("t2_ram0", mem[0], 16'hA53C);
    chk("t2_ptr", dut.cpuptr, 2);
    chk("t2_we_cycles", we_cycles - we0, 2);

    // Lookup and write presented together: lookup keeps idle latency, write still lands
    b = 8'h5A;
    din = b;
    cpuwrite = 1'b1;
    key_lookup(11'h400 + 11'($urandom_range(0, 1023)), 1'b1);
    repeat (7) tick();
    cpuwrite = 1'b0;
    repeat (4) tick();
    ref_wr(b);
    chk("t3_ram1", mem[1], ref_mem[1]);
    chk("t3_ptr", dut.cpuptr, ref_ptr);

    // Long read hold with a lookup serviced in the middle
    e_rd = exp_rd_byte(ref_ptr);
    cpuread = 1'b1;
    repeat (7) tick();
    key_lookup(11'h400 + 11'($urandom_range(0, 1023)), 1'b0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (key_ack && seen == 0) begin
        seen = 1;
        chk("t4_state_at_ack", dut.state_q, ST_CPUWAIT);
      end
    end
    repeat (2) tick();
    cpuread = 1'b0;
    repeat (4) tick();
    ref_ptr = ref_ptr + 12'd1;
    chk("t4_ack_seen", seen, 1);
    chk("t4_dout", dout, e_rd);
    chk("t4_ptr", dut.cpuptr, ref_ptr);

    // Back-to-back lookups every 3 cycles
    for (int j = 0; j < 4; j++) begin
      key_lookup(11'h400 + 11'($urandom_range(0, 1023)), 1'b1);
      repeat (2) tick();
    end
    repeat (6) tick();

    // Random mix of writes, reads and lookups
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 2);
      ka = 11'h400 + 11'($urandom_range(0, 1023));
      if (op == 2) begin
        key_lookup(ka, 1'b1);
        repeat (4) tick();
      end else begin
        b = 8'($urandom);
        e_rd = exp_rd_byte(ref_ptr);
        din = b;
        if (op == 0) cpuwrite = 1'b1;
        else         cpuread  = 1'b1;
        tick();
        if ($urandom_range(0, 1) == 1) key_lookup(ka, 1'b0);
        else                           tick();
        repeat (7) tick();
        cpuwrite = 1'b0;
        cpuread  = 1'b0;
        repeat (4) tick();
        if (op == 0) begin
          ref_wr(b);
        end else begin
          chk("rnd_rd", dout, e_rd);
          ref_ptr = ref_ptr + 12'd1;
        end
      end
    end
    chk("rnd_ptr", dut.cpuptr, ref_ptr);
    for (int w = 0; w < 32; w++) chk("rnd_mem", mem[w], ref_mem[w]);

    // Pointer wrap: sweep to 12'hFFF, then one more read
    rewind_ptr();
    for (int s = 0; s < 4095; s++) cpu_read(4, 2, (s % 1024) == 0, "sweep_rd");
    chk("t7_ptr_fff", dut.cpuptr, 12'hFFF);
    cpu_read(4, 3, 1'b1, "t7_wrap_byte");
    chk("t7_ptr_wrap", dut.cpuptr, 0);

    // Reset while a lookup sits in KEYRD
    key_lookup(11'h400 + 11'($urandom_range(0, 1023)), 1'b1);
    tick();
    chk("t8_in_keyrd", dut.state_q, ST_KEYRD);
    rst = 1'b1;
    exp_q.delete();
    a0 = ack_cnt;
    tick();
    chk("t8_state",    dut.state_q, ST_IDLE);
    chk("t8_key_ack",  key_ack,  0);
    chk("t8_key_data", key_data, 16'h0000);
    chk("t8_dout",     dout,     8'hFF);
    chk("t8_ram_addr", ram_addr, 0);
    chk("t8_ram_we",   ram_we,   2'b00);
    chk("t8_cpuptr",   dut.cpuptr, 0);
    rst = 1'b0;
    repeat (6) tick();
    chk("t8_no_ack", ack_cnt - a0, 0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/keymap_access_ctrl.md
# keymap_access_ctrl

Controller for the single-port 2K×16 keymap RAM behind the Spectrum keyboard matrix. It shares the RAM between two requesters:
- the scancode translator, which performs a lookup on each received scan;
- the CPU keymap load/readback port, which uses an auto-incrementing byte pointer.

Each 16-bit word is {row1[2:0],col1[4:0],row2[2:0],col2[4:0]}. The block sits between the keyboard translation FSM and the keymap BRAM, in the PS/2 clock domain.

## Interface
Parameters:
- KM_AW, 11, keymap word address width
- CPU_AW, 12, CPU byte pointer width (KM_AW+1)

Ports:
- clk  in  1  PS/2-domain clock
- rst  in  1  reset, synchronous, active-high
- key_req  in  1  one-cycle lookup strobe from translator
- key_addr  in  11  {modifiers[2:0],extended,scan[6:0]}, sampled with key_req
- key_ack  out  1  one-cycle pulse, key_data valid
- key_data  out  16  looked-up word, held until next ack
- cpuread  in  1  level, held for whole CPU read access
- cpuwrite  in  1  level, held for whole CPU write access
- rewind  in  1  level, resets CPU pointer
- din  in  8  CPU write byte
- dout  out  8  CPU read byte, held until next CPU read
- ram_addr  out  11  RAM address (registered)
- ram_we  out  2  byte write enables, [1]=keymap1 byte, [0]=keymap2 byte
- ram_wdata  out  16  {din,din}
- ram_rdata  in  16  RAM read data, 1-cycle latency

## Operation
States:
- IDLE
- KEYRD: address issued
- KEYRET: capture data
- CPURD
- CPURDDAT
- CPUWR
- CPUWAIT: wait for strobe release

Request capture:
- key_req sets key_pending and latches key_addr.
- A new key_req while pending overwrites the latched address (latest wins).

IDLE priority:
1. key_pending → load ram_addr, clear pending, go to KEYRD.
2. rewind → cpuptr=0, stay in IDLE.
3. cpuread → ram_addr=cpuptr[11:1], go to CPURD.
4. cpuwrite → ram_addr=cpuptr[11:1], ram_we per cpuptr[0] (0→2'b10, 1→2'b01) for one cycle, go to CPUWR.

Key lookup path:
- KEYRD→KEYRET.
- In KEYRET: key_data<=ram_rdata, key_ack=1. Return to IDLE, or to CPUWAIT if the lookup was entered from CPUWAIT.

CPU read path:
- CPURD→CPURDDAT.
- In CPURDDAT: dout<=cpuptr[0] ? ram_rdata[7:0] : ram_rdata[15:8]. Go to CPUWAIT.

CPU write path:
- CPUWR→CPUWAIT.

CPUWAIT:
- key_pending → service the lookup (KEYRD/KEYRET) with a return flag set, then come back to CPUWAIT.
- cpuread=0 and cpuwrite=0 → cpuptr<=cpuptr+1, go to IDLE. The pointer increments exactly once per access.

Boundary behaviour:
- cpuptr wraps 12'hFFF→12'h000.
- rewind is ignored outside IDLE.
- An unknown state encoding → IDLE.

## Timing
- Reset values: key_ack=0, key_data=16'h0000, dout=8'hFF, ram_addr=0, ram_we=2'b00, cpuptr=0, key_pending=0, state=IDLE.
- Reset applies mid-operation and drops any pending lookup.
- Key lookup latency: key_req at edge N, IDLE at N+1, KEYRD at N+2, key_ack high during cycle N+3. Latency is longer if a CPU access is in flight: at most 3 extra cycles.
- ram_we is asserted exactly one cycle per CPU write.
- Back-to-back key_req is allowed every 3 cycles with no loss.

## Configuration
- KEYMAP_READBACK_EN defined: the CPU read path is implemented as described.
- Undefined: cpuread skips CPURD/CPURDDAT, goes IDLE→CPUWAIT directly, and dout stays 8'hFF. The pointer still increments on release.

## Structure
- Package keymap_pkg holds:
  - state enum;
  - KM_AW/CPU_AW constants;
  - keymap word field offsets (row1/col1/row2/col2);
  - byte-enable constants KM1_BE=2'b10, KM2_BE=2'b01.
- One natural sub-module: keymap_cpu_ptr. It is a 12-bit pointer with rewind/increment and provides word address and lane select.

## Test plan
- Reset, then key_req addr=11'h01C with RAM word 16'h2144 → key_ack at N+3, key_data=16'h2144.
- CPU writes 8'hA5 then 8'h3C after rewind → RAM[0]=16'hA53C, cpuptr=2, one ram_we pulse per write.
- key_req and cpuwrite in the same cycle → lookup completes first, then the write. Neither is lost.
- Hold cpuread 20 cycles with key_req mid-hold → key_ack during CPUWAIT, single pointer increment on release.
- cpuptr=12'hFFF, one read → pointer wraps to 0. Readback byte = RAM[11'h7FF][7:0] with KEYMAP_READBACK_EN, 8'hFF without.
- Assert rst in KEYRD → next cycle state IDLE, no key_ack, all outputs at reset values.
